// File: rtl/scs8hd_and2b_exer.sv
// -----------------------------------------------------------------------------
// scs8hd_and2b_exer
//
// Driving and checking end of the and2b pin interface. Each run walks every
// {AN,B} combination in Gray order (00, 01, 11, 10) NUM_PASSES times. Each
// vector is held for SETTLE_CYC cycles and then for one SAMPLE cycle. At the
// edge that closes the SAMPLE cycle, the returned X is compared with ~AN & B.
// A run reports a one-cycle DONE pulse, a PASS flag, a saturating mismatch
// count and the first failing vector.
//
// Optional feature (macro SCS8HD_EXER_LFSR_EN): after the exhaustive passes,
// 16 extra vectors are drawn from a 4-bit LFSR (x^4+x^3+1). The LFSR is seeded
// with 4'b1001 at START. Its low two bits are driven as {AN,B}. The LFSR steps
// once per SAMPLE while those extra vectors are running.
//
// Ports:
//   CLK       in   clock, rising edge
//   RESETB    in   synchronous active-low reset
//   START     in   begin a run (only looked at in IDLE)
//   AN, B     out  pins driven into the cell under test
//   X         in   output pin of the cell under test
//   BUSY      out  run in progress
//   DONE      out  one-cycle end-of-run pulse
//   PASS      out  last run had zero mismatches (held until next START)
//   ERR_CNT   out  mismatch count, saturates at all-ones
//   FAIL_VEC  out  {AN,B} of the first mismatch
//
// Handshake: START is a level that is sampled only while IDLE. If START is
// held high, a new run starts on every IDLE cycle. DONE is a pulse that needs
// no acknowledgement.
// -----------------------------------------------------------------------------
module scs8hd_and2b_exer #(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_PASSES = 4,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    output logic             AN,
    output logic             B,
    input  logic             X,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [1:0]       FAIL_VEC
);

    localparam int NUM_EXH = 4 * NUM_PASSES;
`ifdef SCS8HD_EXER_LFSR_EN
    localparam int NUM_VEC = NUM_EXH + 16;
`else
    localparam int NUM_VEC = NUM_EXH;
`endif
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [8:0] LAST_IDX    = 9'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       settle_cnt;
    logic [8:0]       vec_idx;
    logic [8:0]       vec_idx_next;
    logic [1:0]       vec_next;
    logic             expected;
    logic             mismatch;
    logic             last_vec;
    logic             settle_done;
    logic             first_err;
    logic [ERR_W-1:0] err_next;

`ifdef SCS8HD_EXER_LFSR_EN
    localparam logic [8:0] FIRST_RAND_IDX = 9'(NUM_EXH);
    localparam logic [3:0] LFSR_SEED      = 4'b1001;
    logic [3:0] lfsr;
    logic [3:0] lfsr_next;
`endif

    always_comb begin
        state_next   = state;
        expected     = ~AN & B;
        // Case inequality so that an unknown X from the cell counts as a miss.
        mismatch     = (X !== expected);
        last_vec     = (vec_idx == LAST_IDX);
        settle_done  = (settle_cnt == 4'd0);
        first_err    = mismatch && (ERR_CNT == '0);
        err_next     = ERR_CNT;
        if (mismatch && (ERR_CNT != '1)) begin
            err_next = ERR_CNT + ERR_W'(1);
        end
        vec_idx_next = vec_idx + 9'd1;
        // Gray walk 00, 01, 11, 10. The low index bits wrap into the next pass.
        vec_next     = {vec_idx_next[1], vec_idx_next[1] ^ vec_idx_next[0]};
`ifdef SCS8HD_EXER_LFSR_EN
        lfsr_next = lfsr;
        // The LFSR only advances once the random vectors are being sampled.
        // This makes the first random vector always the seed's low bits.
        if (vec_idx >= FIRST_RAND_IDX) begin
            lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
        if (vec_idx_next >= FIRST_RAND_IDX) begin
            vec_next = lfsr_next[1:0];
        end
`endif
        case (state)
            IDLE:    if (START) state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = SAMPLE;
            SAMPLE:  state_next = last_vec ? FIN : SETTLE;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state      <= IDLE;
            AN         <= 1'b1;
            B          <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VEC   <= 2'b00;
            settle_cnt <= 4'd0;
            vec_idx    <= 9'd0;
`ifdef SCS8HD_EXER_LFSR_EN
            lfsr       <= LFSR_SEED;
`endif
        end else begin
            state <= state_next;
            DONE  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        AN         <= 1'b0;
                        B          <= 1'b0;
                        BUSY       <= 1'b1;
                        PASS       <= 1'b0;
                        ERR_CNT    <= '0;
                        FAIL_VEC   <= 2'b00;
                        settle_cnt <= SETTLE_LOAD;
                        vec_idx    <= 9'd0;
`ifdef SCS8HD_EXER_LFSR_EN
                        lfsr       <= LFSR_SEED;
`endif
                    end
                end
                SETTLE: begin
                    if (!settle_done) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    ERR_CNT <= err_next;
                    if (first_err) begin
                        FAIL_VEC <= {AN, B};
                    end
                    if (last_vec) begin
                        AN   <= 1'b1;
                        B    <= 1'b0;
                        DONE <= 1'b1;
                        PASS <= (err_next == '0);
                    end else begin
                        AN         <= vec_next[1];
                        B          <= vec_next[0];
                        vec_idx    <= vec_idx_next;
                        settle_cnt <= SETTLE_LOAD;
`ifdef SCS8HD_EXER_LFSR_EN
                        lfsr       <= lfsr_next;
`endif
                    end
                end
                FIN: begin
                    BUSY <= 1'b0;
                end
                default: begin
                    BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scs8hd_and2b_exer.sv
// -----------------------------------------------------------------------------
// Bench for scs8hd_and2b_exer. There are two instances: one with default
// parameters and one with ERR_W=3, so that saturation can be observed.
// Each instance gets its X pin from a behavioural and2b cell. The cell has a
// selectable behaviour: ideal, stuck-0, stuck-1, noisy, or unknown.
//
// The reference model tracks each run as "edges since START". The driven
// vector is rel / (SETTLE_CYC+1). A SAMPLE closes every (SETTLE_CYC+1) edges.
// -----------------------------------------------------------------------------
module tb_scs8hd_and2b_exer;

    localparam int S  = 2;
    localparam int NP = 4;
    localparam int P  = S + 1;
`ifdef SCS8HD_EXER_LFSR_EN
    localparam int V       = 4 * NP + 16;
    localparam int EXP_LAT = 96;
`else
    localparam int V       = 4 * NP;
    localparam int EXP_LAT = 48;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetb;
    logic start;
    always #5 clk = ~clk;

    // ---------------- DUTs and cell models ----------------
    logic       an_main, b_main, x_main, busy_main, done_main, pass_main;
    logic [7:0] err_main;
    logic [1:0] fvec_main;
    logic       an_sat, b_sat, x_sat, busy_sat, done_sat, pass_sat;
    logic [2:0] err_sat;
    logic [1:0] fvec_sat;

    int   x_mode = 0;
    logic noise  = 1'b0;

    function automatic logic cell_x(input int mode, input logic a_n, input logic bb, input logic nz);
        case (mode)
            0:       return ~a_n & bb;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (~a_n & bb) ^ nz;
            default: return 1'bx;
        endcase
    endfunction

    assign x_main = cell_x(x_mode, an_main, b_main, noise);
    assign x_sat  = cell_x(x_mode, an_sat, b_sat, noise);

    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    scs8hd_and2b_exer #(.SETTLE_CYC(S), .NUM_PASSES(NP), .ERR_W(8)) dut (
        .CLK(clk), .RESETB(resetb), .START(start),
        .AN(an_main), .B(b_main), .X(x_main),
        .BUSY(busy_main), .DONE(done_main), .PASS(pass_main),
        .ERR_CNT(err_main), .FAIL_VEC(fvec_main)
    );

    scs8hd_and2b_exer #(.SETTLE_CYC(S), .NUM_PASSES(NP), .ERR_W(3)) dut_sat (
        .CLK(clk), .RESETB(resetb), .START(start),
        .AN(an_sat), .B(b_sat), .X(x_sat),
        .BUSY(busy_sat), .DONE(done_sat), .PASS(pass_sat),
        .ERR_CNT(err_sat), .FAIL_VEC(fvec_sat)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    // ---------------- reference model ----------------
    int gray_tab[4] = '{0, 1, 3, 2};
    int lfsr_tab[16];
    int edge_n  = 0;
    bit m_valid = 0;
    int m_state = 0;   // 0 idle, 1 running, 2 done cycle
    int m_rel   = 0;
    int m_err   = 0;
    int m_fvec  = 0;
    int m_pass  = 0;

    initial begin
        int l;
        int fb;
        l = 9;
        for (int i = 0; i < 16; i++) begin
            lfsr_tab[i] = l;
            fb = ((l >> 3) ^ (l >> 2)) & 1;
            l  = ((l << 1) | fb) & 15;
        end
    end

    function automatic int vec_of(input int v);
        if (v < 4 * NP) return gray_tab[v % 4];
        return lfsr_tab[v - 4 * NP] & 3;
    endfunction

    always @(posedge clk) begin
        int v;
        int pv;
        logic ideal;
        edge_n++;
        if (resetb !== 1'b1) begin
            m_state = 0; m_err = 0; m_fvec = 0; m_pass = 0; m_valid = 1;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (start === 1'b1) begin
                m_state = 1; m_rel = 0; m_err = 0; m_fvec = 0; m_pass = 0;
            end
        end else begin
            m_rel++;
            if (m_rel % P == 0) begin
                v     = m_rel / P - 1;
                pv    = vec_of(v);
                ideal = (((pv >> 1) & 1) == 0) && ((pv & 1) == 1);
                if (x_main !== ideal) begin
                    if (m_err == 0) m_fvec = pv;
                    m_err++;
                end
                if (v == V - 1) begin
                    m_state = 2;
                    m_pass  = (m_err == 0) ? 1 : 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int pins;
        int sat;
        if (m_valid) begin
            pins = (m_state == 1) ? vec_of(m_rel / P) : 2;
            sat  = (m_err > 7) ? 7 : m_err;
            chk("busy",      busy_main, (m_state != 0) ? 1 : 0);
            chk("done",      done_main, (m_state == 2) ? 1 : 0);
            chk("pass",      pass_main, m_pass);
            chk("an",        an_main,   (pins >> 1) & 1);
            chk("b",         b_main,    pins & 1);
            chk("err_cnt",   err_main,  m_err);
            chk("fail_vec",  fvec_main, m_fvec);
            chk("sat_err",   err_sat,   sat);
            chk("sat_done",  done_sat,  (m_state == 2) ? 1 : 0);
            chk("sat_fvec",  fvec_sat,  m_fvec);
        end
    end

    // ---------------- driver tasks ----------------
    logic [1:0] snap_pins = 2'b00;

    task automatic do_run(input int mode, output int lat);
        int e0;
        x_mode = mode;
        start  = 1'b1;
        e0     = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int i = 0; i < 4000; i++) begin
            if (edge_n == e0 + 4 * NP * P) snap_pins = {an_main, b_main};
            if (done_main === 1'b1) begin
                lat = edge_n - e0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("run_done_seen", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_main !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (busy_main !== 1'b0) chk("idle_reached", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int cnt;
        int e0;
        int rst_at;
        resetb = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        // Ideal cell
        do_run(0, lat);
        chk("t1_latency", lat, EXP_LAT);
        chk("t1_pass", pass_main, 1);
        chk("t1_err", err_main, 0);
`ifdef SCS8HD_EXER_LFSR_EN
        chk("t6_first_rand_vec", snap_pins, 2'b01);
`endif

        // X stuck at 0 / stuck at 1
        do_run(1, lat);
`ifndef SCS8HD_EXER_LFSR_EN
        chk("t2_err", err_main, 4);
`endif
        chk("t2_fvec", fvec_main, 2'b01);
        chk("t2_pass", pass_main, 0);
        do_run(2, lat);
`ifndef SCS8HD_EXER_LFSR_EN
        chk("t3_err", err_main, 12);
`endif
        chk("t3_fvec", fvec_main, 2'b00);
        chk("t3_sat_err", err_sat, 7);

        // Reset for one edge at e0+20
        x_mode = 2;
        start  = 1'b1;
        e0     = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_n < e0 + 19) @(negedge clk);
        chk("t4_pre_reset_err", err_main, 4);
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        chk("t4_busy", busy_main, 0);
        chk("t4_an", an_main, 1);
        chk("t4_b", b_main, 0);
        chk("t4_err", err_main, 0);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_main === 1'b1) cnt++;
        end
        chk("t4_no_done", cnt, 0);
        do_run(0, lat);
        chk("t4_rerun_latency", lat, EXP_LAT);

        // START held high through two full runs
        x_mode = 2;
        start  = 1'b1;
        cnt    = 0;
        repeat (2 * V * P + 6) begin
            @(negedge clk);
            if (done_main === 1'b1) cnt++;
        end
        chk("t5_held_dones", cnt, 2);
        start = 1'b0;
        wait_idle();

        // Unknown value on X
        do_run(4, lat);
        chk("tx_pass", pass_main, 0);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            x_mode = $urandom_range(0, 4);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, V * P)) : -1;
            for (int i = 1; i < V * P + 4; i++) begin
                start  = ($urandom_range(0, 7) == 0);
                resetb = (i != rst_at);
                @(negedge clk);
            end
            start  = 1'b0;
            resetb = 1'b1;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scs8hd_and2b_exer.md
# scs8hd_and2b_exer

Self-checking exerciser for the `scs8hd_and2b` cell family. It drives the inverted-enable input `AN` and the data input `B` of a cell under test. It samples the cell's `X` output after a programmable settle time and compares it against `X = ~AN & B`. It reports pass/fail, a saturating error count and the first failing vector. It sits in the cell-library characterisation bench as the driving and checking end of the and2b pin interface.

## Interface

Parameters:
- `SETTLE_CYC`, default 2: cycles between driving a vector and the sampling cycle. Legal range 1..15.
- `NUM_PASSES`, default 4: number of exhaustive 4-vector sweeps. Legal range 1..64.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `CLK` input, 1: clock; all state changes on the rising edge.
- `RESETB` input, 1: synchronous, active-low reset.
- `START` input, 1: begin a run; sampled only in IDLE.
- `AN` output, 1: drives the `AN` pin of the cell under test.
- `B` output, 1: drives the `B` pin of the cell under test.
- `X` input, 1: `X` pin of the cell under test.
- `BUSY` output, 1: high while a run is in progress.
- `DONE` output, 1: one-cycle pulse at the end of a run.
- `PASS` output, 1: 1 when the last run had zero mismatches; held until the next START.
- `ERR_CNT` output, ERR_W: mismatch count of the last or current run; saturates at all-ones.
- `FAIL_VEC` output, 2: `{AN,B}` of the first mismatch; valid when `ERR_CNT != 0`.

## Operation

- **Reset values:** `AN=1`, `B=0`, `BUSY=0`, `DONE=0`, `PASS=0`, `ERR_CNT=0`, `FAIL_VEC=2'b00`, state IDLE.
- **FSM states:** IDLE, SETTLE, SAMPLE, FIN.
- **IDLE → SETTLE** when `START=1`. On that edge:
  - load vector 0;
  - clear `ERR_CNT`, `FAIL_VEC` and `PASS`;
  - load the settle counter with `SETTLE_CYC-1`.
- **SETTLE:** decrement the counter; go to SAMPLE when the counter reaches 0. SETTLE lasts exactly `SETTLE_CYC` cycles.
- **SAMPLE:** one cycle; compare `X` at the closing edge.
  - On a mismatch, `ERR_CNT` increments unless it is all-ones.
  - If this is the first mismatch (`ERR_CNT==0` before the increment), capture `FAIL_VEC`.
  - On the same edge: if this is the last vector, go to FIN; otherwise drive the next vector and go to SETTLE.
- **FIN:** `DONE=1` and `PASS=(ERR_CNT==0)` for this cycle, then IDLE. `BUSY` falls on entry to IDLE.
- **Vector order per pass:** `{AN,B}` = 00, 01, 11, 10 (Gray order, one pin toggles per step). The index wraps 3→0 into the next pass. `AN`/`B` return to 1/0 on FIN entry.
- **Expected value:** `~AN & B` of the currently driven vector. In simulation an `X` or `Z` on the `X` input counts as a mismatch (case-inequality compare).
- **START** outside IDLE (including the FIN cycle) is ignored. A held-high START re-triggers in the first IDLE cycle after FIN.
- **RESETB low during a run:** all outputs take their reset values at the next edge; no DONE pulse is produced.

## Timing

- V = total vectors, 4·NUM_PASSES (see Configuration).
- Each vector takes `SETTLE_CYC+1` cycles.
- With START accepted at edge e0:
  - `BUSY=1` from e0;
  - the last SAMPLE closes at edge e0 + V·(SETTLE_CYC+1);
  - `DONE` is high during the following cycle.
- Defaults: V=16, DONE high in the cycle after edge e0+48.
- `AN`, `B`, `BUSY`, `DONE`, `PASS`, `ERR_CNT` and `FAIL_VEC` are all registered. `X` is sampled combinationally only at the SAMPLE edge.

## Configuration

- Macro: `SCS8HD_EXER_LFSR_EN`.
- **Defined:**
  - after the exhaustive passes, 16 additional pseudo-random vectors run;
  - a 4-bit LFSR (x⁴+x³+1, seeded 4'b1001 at START, stepped once per SAMPLE) supplies them, with `{AN,B}` = `lfsr[1:0]`;
  - V = 4·NUM_PASSES + 16.
- **Undefined:** no LFSR logic is built; V = 4·NUM_PASSES.

## Test plan

1. Ideal model `X=~AN&B`, defaults, START pulse at e0:
   - `AN,B` cycle 00,01,11,10 four times;
   - DONE in the cycle after e0+48;
   - `PASS=1`, `ERR_CNT=0`.
2. `X` stuck at 0: mismatch only on vector 01, so `ERR_CNT=4`, `FAIL_VEC=2'b01`, `PASS=0`.
3. `X` stuck at 1: 3 mismatches per pass, so `ERR_CNT=12`, `FAIL_VEC=2'b00`. Repeat with `ERR_W=3`: `ERR_CNT` saturates at 7.
4. `RESETB` low for one edge at e0+20:
   - next cycle `BUSY=0`, `AN=1`, `B=0`, `ERR_CNT=0`;
   - no DONE;
   - a new START runs a full 48-cycle sequence.
5. START held high throughout:
   - pulses mid-run are ignored;
   - a second run starts in the first IDLE cycle after FIN;
   - `ERR_CNT` is cleared at that start.
6. `SCS8HD_EXER_LFSR_EN` defined, ideal model, defaults:
   - the first LFSR vector is `{AN,B}=2'b01`;
   - DONE in the cycle after e0+96;
   - `PASS=1`.
